// File: rtl/laser_sweep_ctrl.sv
// Per-revolution laser turret sequencer: filters detector edges, pairs them into beacon slots and
// publishes a ping-pong frame of beacon angles on every index pulse.
module laser_sweep_ctrl #(
    parameter int unsigned MAX_BEACONS = 4,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        laser_signal,
    input  logic        laser_sync,
    input  logic [15:0] position,
    input  logic        rd_en,
    input  logic [2:0]  rd_addr,
    output logic        rd_valid,
    output logic [15:0] rd_rise,
    output logic [15:0] rd_fall,
    output logic [3:0]  frame_count,
    output logic        frame_valid,
    output logic [7:0]  frame_seq,
    output logic        overflow,
    output logic        stalled
);

    localparam int unsigned SW    = (MAX_BEACONS > 1) ? $clog2(MAX_BEACONS) : 1;
    localparam int unsigned DEPTH = 1 << SW;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StWaitSync, StLow, StHigh} state_e;

    state_e state_q, state_d;

    logic laser_s1_q, laser_s2_q;
    logic sync_s1_q, sync_s2_q, sync_s3_q;
    logic sync_evt;

    logic       lvl_q;
    logic [7:0] filt_cnt_q;
    logic       mismatch, filt_hit, rise_evt, fall_evt;

    logic [TW-1:0] to_cnt_q;
    logic          timeout_hit;
    logic          stalled_q;

    logic          commit, wr_pair, set_ovf, latch_rise, clear_work;
    logic          wr_room;
    logic          work_sel_q;
    logic [3:0]    work_cnt_q;
    logic          work_ovf_q;
    logic [15:0]   rise_tmp_q;
    logic [15:0]   rise_mem_q [2][DEPTH];
    logic [15:0]   fall_mem_q [2][DEPTH];
    logic [SW-1:0] wr_slot, rd_slot;
    logic          pub_sel;
    logic          rd_hit;

    logic [3:0]  frame_count_q;
    logic        overflow_q;
    logic [7:0]  frame_seq_q;
    logic        frame_valid_q;
    logic        rd_valid_q;
    logic [15:0] rd_rise_q, rd_fall_q;

    // Input synchronizers; sync_s3_q only exists to find the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            laser_s1_q <= 1'b0;
            laser_s2_q <= 1'b0;
            sync_s1_q  <= 1'b0;
            sync_s2_q  <= 1'b0;
            sync_s3_q  <= 1'b0;
        end else begin
            laser_s1_q <= laser_signal;
            laser_s2_q <= laser_s1_q;
            sync_s1_q  <= laser_sync;
            sync_s2_q  <= sync_s1_q;
            sync_s3_q  <= sync_s2_q;
        end
    end

    assign sync_evt = sync_s2_q & ~sync_s3_q;

    assign mismatch = laser_s2_q != lvl_q;
    assign filt_hit = mismatch && (filt_cnt_q == 8'(FILTER_LEN - 1));
    assign rise_evt = filt_hit & ~lvl_q;
    assign fall_evt = filt_hit & lvl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q      <= 1'b0;
            filt_cnt_q <= 8'd0;
        end else if (!mismatch) begin
            filt_cnt_q <= 8'd0;
        end else if (filt_hit) begin
            filt_cnt_q <= 8'd0;
            lvl_q      <= ~lvl_q;
        end else begin
            filt_cnt_q <= filt_cnt_q + 8'd1;
        end
    end

    // A sync in the same cycle as the final count wins over the timeout.
    assign timeout_hit = (state_q != StWaitSync) && !sync_evt &&
                         (to_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= '0;
            stalled_q <= 1'b0;
        end else begin
            if (sync_evt || timeout_hit) begin
                to_cnt_q <= '0;
            end else if (state_q != StWaitSync) begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end
            if (timeout_hit) begin
                stalled_q <= 1'b1;
            end else if (sync_evt) begin
                stalled_q <= 1'b0;
            end
        end
    end

    assign wr_room = work_cnt_q < 4'(MAX_BEACONS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWaitSync;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        commit     = 1'b0;
        wr_pair    = 1'b0;
        set_ovf    = 1'b0;
        latch_rise = 1'b0;
        clear_work = 1'b0;
        unique case (state_q)
            StWaitSync: begin
                if (sync_evt) begin
                    state_d    = StLow;
                    clear_work = 1'b1;
                end
            end
            StLow: begin
                if (rise_evt) begin
                    latch_rise = 1'b1;
                    state_d    = StHigh;
                end
                if (sync_evt) begin
                    commit = 1'b1;
                end
            end
            StHigh: begin
                if (fall_evt) begin
                    state_d = StLow;
                    if (wr_room) begin
                        wr_pair = 1'b1;
                    end else begin
                        set_ovf = 1'b1;
                    end
                end
                // An open beacon at sync is dropped; a closing one was already paired above.
                if (sync_evt) begin
                    commit  = 1'b1;
                    state_d = StLow;
                end
            end
            default: state_d = StWaitSync;
        endcase
        if (timeout_hit) begin
            state_d    = StWaitSync;
            clear_work = 1'b1;
            wr_pair    = 1'b0;
            set_ovf    = 1'b0;
            latch_rise = 1'b0;
        end
    end

    assign wr_slot = work_cnt_q[SW-1:0];
    assign pub_sel = ~work_sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            work_sel_q <= 1'b0;
            work_cnt_q <= 4'd0;
            work_ovf_q <= 1'b0;
            rise_tmp_q <= 16'd0;
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < int'(DEPTH); s++) begin
                    rise_mem_q[b][s] <= 16'd0;
                    fall_mem_q[b][s] <= 16'd0;
                end
            end
        end else begin
            if (latch_rise) begin
                rise_tmp_q <= position;
            end
            if (wr_pair) begin
                rise_mem_q[work_sel_q][wr_slot] <= rise_tmp_q;
                fall_mem_q[work_sel_q][wr_slot] <= position;
            end
            if (commit) begin
                work_sel_q <= ~work_sel_q;
                work_cnt_q <= 4'd0;
                work_ovf_q <= 1'b0;
            end else if (clear_work) begin
                work_cnt_q <= 4'd0;
                work_ovf_q <= 1'b0;
            end else begin
                if (wr_pair) begin
                    work_cnt_q <= work_cnt_q + 4'd1;
                end
                if (set_ovf) begin
                    work_ovf_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= 4'd0;
            overflow_q    <= 1'b0;
            frame_seq_q   <= 8'd0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= commit;
            if (commit) begin
                frame_count_q <= work_cnt_q + {3'b000, wr_pair};
                overflow_q    <= work_ovf_q | set_ovf;
                frame_seq_q   <= frame_seq_q + 8'd1;
            end
        end
    end

    // Read sees the pre-commit bank and count when it lands on the commit edge.
    assign rd_slot = rd_addr[SW-1:0];
    assign rd_hit  = {1'b0, rd_addr} < frame_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_rise_q  <= 16'd0;
            rd_fall_q  <= 16'd0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_rise_q <= rd_hit ? rise_mem_q[pub_sel][rd_slot] : 16'd0;
                rd_fall_q <= rd_hit ? fall_mem_q[pub_sel][rd_slot] : 16'd0;
            end
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_rise     = rd_rise_q;
    assign rd_fall     = rd_fall_q;
    assign frame_count = frame_count_q;
    assign frame_valid = frame_valid_q;
    assign frame_seq   = frame_seq_q;
    assign overflow    = overflow_q;
    assign stalled     = stalled_q;

endmodule
